// File: rtl/draw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : draw_pkg                                                        |
// | Purpose  : Shared pattern-mode constants and sweep FSM state encoding for  |
// |            the draw_sweep frame-drawing engine.                            |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package draw_pkg;

  localparam logic [1:0] MODE_SOLID    = 2'd0;
  localparam logic [1:0] MODE_GRADIENT = 2'd1;
  localparam logic [1:0] MODE_CHECKER  = 2'd2;
  localparam logic [1:0] MODE_BORDER   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/draw_sweep_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : draw_sweep_if                                                   |
// | Purpose  : Pixel write-command channel toward the VGA controller, with a   |
// |            valid/ready handshake.                                          |
// | Ports    : X, Y (address), R, G, B (colour), WVALID (master -> slave),     |
// |            WREADY (slave -> master)                                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface draw_sweep_if #(
  parameter int X_W = 8,
  parameter int Y_W = 8,
  parameter int C_W = 3
);
  logic [X_W-1:0] X;
  logic [Y_W-1:0] Y;
  logic [C_W-1:0] R;
  logic [C_W-1:0] G;
  logic [C_W-1:0] B;
  logic           WVALID;
  logic           WREADY;

  modport master (output X, Y, R, G, B, WVALID, input  WREADY);
  modport slave  (input  X, Y, R, G, B, WVALID, output WREADY);
endinterface
`default_nettype wire

// File: rtl/draw_shade.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : draw_shade                                                      |
// | Purpose  : Combinational pixel colour generator for the four pattern modes |
// |            (solid, gradient, checkerboard, border).                        |
// | Ports    : MODE (pattern), X/Y (pixel), COLOR ({R,G,B} base), FRAME       |
// |            (frame count for animation) -> RGB ({R,G,B} result)            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module draw_shade
  import draw_pkg::*;
#(
  parameter int WIDTH     = 256,
  parameter int HEIGHT    = 256,
  parameter int X_W       = 8,
  parameter int Y_W       = 8,
  parameter int C_W       = 3,
  parameter int TILE_LOG2 = 3
) (
  input  wire logic [1:0]       MODE,
  input  wire logic [X_W-1:0]   X,
  input  wire logic [Y_W-1:0]   Y,
  input  wire logic [3*C_W-1:0] COLOR,
  input  wire logic [7:0]       FRAME,
  output logic      [3*C_W-1:0] RGB
);

  logic           w_tx;     // bit 0 of X >> TILE_LOG2
  logic           w_ty;     // bit 0 of Y >> TILE_LOG2
  logic           w_edge;
  logic [C_W-1:0] w_sum;

  // A tile index beyond the coordinate width is always zero.
  if (TILE_LOG2 < X_W) begin : g_tx
    assign w_tx = X[TILE_LOG2];
  end else begin : g_tx_zero
    assign w_tx = 1'b0;
  end

  if (TILE_LOG2 < Y_W) begin : g_ty
    assign w_ty = Y[TILE_LOG2];
  end else begin : g_ty_zero
    assign w_ty = 1'b0;
  end

  // Only the low C_W bits of x + y + frame survive truncation, so adding
  // the truncated operands gives the same modulo result.
  assign w_sum  = C_W'(X) + C_W'(Y) + C_W'(FRAME);
  assign w_edge = (X == '0) || (X == X_W'(WIDTH - 1)) ||
                  (Y == '0) || (Y == Y_W'(HEIGHT - 1));

  always_comb begin
    RGB = COLOR;
    case (MODE)
      MODE_SOLID:    RGB = COLOR;
      MODE_GRADIENT: RGB = {C_W'(X), C_W'(Y), w_sum};
      MODE_CHECKER:  RGB = (w_tx ^ w_ty) ? COLOR : '0;
      MODE_BORDER:   RGB = w_edge ? COLOR : ~COLOR;
      default:       RGB = COLOR;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/draw_sweep.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : draw_sweep                                                      |
// | Purpose  : Raster-order frame sweep engine; emits one write command per    |
// |            pixel with valid/ready backpressure and start/busy/done control.|
// | Ports    : CLK, RST (sync, active high), START, MODE, COLOR (inputs);      |
// |            BUSY, DONE, FRAME (status); wr (write channel, master side)    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module draw_sweep
  import draw_pkg::*;
#(
  parameter int WIDTH     = 256,
  parameter int HEIGHT    = 256,
  parameter int X_W       = 8,
  parameter int Y_W       = 8,
  parameter int C_W       = 3,
  parameter int TILE_LOG2 = 3
) (
  input  wire logic             CLK,
  input  wire logic             RST,
  input  wire logic             START,
  input  wire logic [1:0]       MODE,
  input  wire logic [3*C_W-1:0] COLOR,
  output logic                  BUSY,
  output logic                  DONE,
  output logic      [7:0]       FRAME,
  draw_sweep_if.master          wr
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [X_W-1:0]   w_x_nxt;
  logic [Y_W-1:0]   w_y_nxt;
  logic [1:0]       r_mode;
  logic [3*C_W-1:0] r_color;
  logic [3*C_W-1:0] r_rgb;
  logic [7:0]       r_frame;
  logic             r_busy;
  logic             r_done;
  logic             r_wvalid;

  logic             w_hs;
  logic             w_last;
  logic             w_start_ok;
  logic             w_load;
  logic [1:0]       w_mode;
  logic [3*C_W-1:0] w_color;
  logic [3*C_W-1:0] w_rgb_nxt;

  assign w_hs       = (r_state == RUN) && wr.WREADY;
  assign w_last     = (r_x == X_W'(WIDTH - 1)) && (r_y == Y_W'(HEIGHT - 1));
  assign w_start_ok = (r_state == IDLE) && START;
  // The final pixel's coordinates are held after its handshake.
  assign w_load     = w_start_ok || (w_hs && !w_last);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    case (r_state)
      IDLE: begin
        if (START) begin
          w_state_nxt = RUN;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
        end
      end
      RUN: begin
        if (w_hs) begin
          if (w_last) begin
            w_state_nxt = FIN;
          end else if (r_x == X_W'(WIDTH - 1)) begin
            w_x_nxt = '0;
            w_y_nxt = r_y + 1'b1;
          end else begin
            w_x_nxt = r_x + 1'b1;
          end
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The shader looks at the coordinate about to be loaded; on the start
  // cycle the mode/colour latches are not yet written, so use the inputs.
  assign w_mode  = w_start_ok ? MODE  : r_mode;
  assign w_color = w_start_ok ? COLOR : r_color;

  draw_shade #(
    .WIDTH     (WIDTH),
    .HEIGHT    (HEIGHT),
    .X_W       (X_W),
    .Y_W       (Y_W),
    .C_W       (C_W),
    .TILE_LOG2 (TILE_LOG2)
  ) u_shade (
    .MODE  (w_mode),
    .X     (w_x_nxt),
    .Y     (w_y_nxt),
    .COLOR (w_color),
    .FRAME (r_frame),
    .RGB   (w_rgb_nxt)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_x      <= '0;
      r_y      <= '0;
      r_rgb    <= '0;
      r_mode   <= '0;
      r_color  <= '0;
      r_frame  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wvalid <= 1'b0;
    end else begin
      r_busy   <= (w_state_nxt != IDLE);
      r_wvalid <= (w_state_nxt == RUN);
      r_done   <= w_hs && w_last;
      if (w_start_ok) begin
        r_mode  <= MODE;
        r_color <= COLOR;
      end
      if (w_load) begin
        r_x   <= w_x_nxt;
        r_y   <= w_y_nxt;
        r_rgb <= w_rgb_nxt;
      end
      // Counted on the transition into FIN so the new count is visible
      // alongside DONE.
      if (w_hs && w_last) r_frame <= r_frame + 8'd1;
    end
  end

  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign FRAME     = r_frame;
  assign wr.X      = r_x;
  assign wr.Y      = r_y;
  assign wr.R      = r_rgb[3*C_W-1:2*C_W];
  assign wr.G      = r_rgb[2*C_W-1:C_W];
  assign wr.B      = r_rgb[C_W-1:0];
  assign wr.WVALID = r_wvalid;

endmodule
`default_nettype wire

// File: tb/tb_draw_sweep.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_draw_sweep                                                   |
// | Purpose  : Self-checking bench for draw_sweep: three instances with        |
// |            different frame geometry, a spec-level behavioural model and    |
// |            directed pixel/timing expectations.                             |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_draw_sweep;

  localparam int PW[3] = '{4, 16, 4};
  localparam int PH[3] = '{2, 16, 4};
  localparam int PT[3] = '{1, 1, 3};

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       rst[3];
  logic       start[3];
  logic       wready[3];
  logic [1:0] mode[3];
  logic [8:0] color[3];

  logic       obusy[3];
  logic       odone[3];
  logic [7:0] ofr[3];
  logic [7:0] ox[3];
  logic [7:0] oy[3];
  logic [8:0] orgb[3];
  logic       owv[3];

  draw_sweep_if #(.X_W(8), .Y_W(8), .C_W(3)) if0 ();
  draw_sweep_if #(.X_W(8), .Y_W(8), .C_W(3)) if1 ();
  draw_sweep_if #(.X_W(8), .Y_W(8), .C_W(3)) if2 ();

  draw_sweep #(.WIDTH(4), .HEIGHT(2), .X_W(8), .Y_W(8), .C_W(3), .TILE_LOG2(1)) dut0 (
    .CLK(CLK), .RST(rst[0]), .START(start[0]), .MODE(mode[0]), .COLOR(color[0]),
    .BUSY(obusy[0]), .DONE(odone[0]), .FRAME(ofr[0]), .wr(if0));
  draw_sweep #(.WIDTH(16), .HEIGHT(16), .X_W(8), .Y_W(8), .C_W(3), .TILE_LOG2(1)) dut1 (
    .CLK(CLK), .RST(rst[1]), .START(start[1]), .MODE(mode[1]), .COLOR(color[1]),
    .BUSY(obusy[1]), .DONE(odone[1]), .FRAME(ofr[1]), .wr(if1));
  draw_sweep #(.WIDTH(4), .HEIGHT(4), .X_W(8), .Y_W(8), .C_W(3), .TILE_LOG2(3)) dut2 (
    .CLK(CLK), .RST(rst[2]), .START(start[2]), .MODE(mode[2]), .COLOR(color[2]),
    .BUSY(obusy[2]), .DONE(odone[2]), .FRAME(ofr[2]), .wr(if2));

  assign if0.WREADY = wready[0];
  assign if1.WREADY = wready[1];
  assign if2.WREADY = wready[2];
  assign ox[0] = if0.X;  assign oy[0] = if0.Y;  assign owv[0] = if0.WVALID;
  assign ox[1] = if1.X;  assign oy[1] = if1.Y;  assign owv[1] = if1.WVALID;
  assign ox[2] = if2.X;  assign oy[2] = if2.Y;  assign owv[2] = if2.WVALID;
  assign orgb[0] = {if0.R, if0.G, if0.B};
  assign orgb[1] = {if1.R, if1.G, if1.B};
  assign orgb[2] = {if2.R, if2.G, if2.B};

  int nvec = 0;
  int nerr = 0;
  logic en = 1'b0;

  task automatic check(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s inst%0d t=%0t got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 drawing, 2 done cycle. idx = pixels already accepted.
  int         phase[3];
  int         idx[3];
  int         frm[3];
  int         gfrm[3];
  logic       rflag[3];
  logic [1:0] mmode[3];
  logic [8:0] mcol[3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      phase[k] = 0; idx[k] = 0; frm[k] = 0; gfrm[k] = 0;
      rflag[k] = 1'b1; mmode[k] = 2'd0; mcol[k] = 9'h0;
    end
  end

  function automatic logic [8:0] mrgb(input int k, input int x, input int y);
    logic [8:0] c;
    int t;
    c = mcol[k];
    t = PT[k];
    case (mmode[k])
      2'd0:    return c;
      2'd1:    return {3'(x % 8), 3'(y % 8), 3'((x + y + gfrm[k]) % 8)};
      2'd2:    return ((((x >> t) ^ (y >> t)) & 1) == 1) ? c : 9'h000;
      default: return (x == 0 || x == PW[k]-1 || y == 0 || y == PH[k]-1) ? c : ~c;
    endcase
  endfunction

  always @(negedge CLK) begin
    if (en) begin
      for (int k = 0; k < 3; k++) begin
        check("frame", k, 32'(ofr[k]), 32'(frm[k]));
        check("busy",  k, 32'(obusy[k]), 32'(phase[k] != 0));
        check("done",  k, 32'(odone[k]), 32'(phase[k] == 2));
        check("wvalid", k, 32'(owv[k]), 32'(phase[k] == 1));
        if (phase[k] == 1) begin
          check("x",   k, 32'(ox[k]), 32'(idx[k] % PW[k]));
          check("y",   k, 32'(oy[k]), 32'(idx[k] / PW[k]));
          check("rgb", k, 32'(orgb[k]), 32'(mrgb(k, idx[k] % PW[k], idx[k] / PW[k])));
        end else if (phase[k] == 0 && rflag[k]) begin
          check("rst_xy",  k, {16'h0, ox[k], oy[k]}, 32'h0);
          check("rst_rgb", k, 32'(orgb[k]), 32'h0);
        end
        // advance to the state after the coming rising edge
        if (rst[k]) begin
          phase[k] = 0; frm[k] = 0; rflag[k] = 1'b1;
        end else if (phase[k] == 0) begin
          if (start[k]) begin
            phase[k] = 1; idx[k] = 0; rflag[k] = 1'b0;
            mmode[k] = mode[k]; mcol[k] = color[k]; gfrm[k] = frm[k];
          end
        end else if (phase[k] == 1) begin
          if (wready[k]) begin
            if (idx[k] == PW[k]*PH[k] - 1) begin
              phase[k] = 2; frm[k] = (frm[k] + 1) % 256;
            end else begin
              idx[k]++;
            end
          end
        end else begin
          phase[k] = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  // Wait (bounded) for pixel (x,y) to be offered and pin its colour.
  task automatic pin(input int k, input int x, input int y, input logic [8:0] exp);
    bit seen = 0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      if (owv[k] && ox[k] == 8'(x) && oy[k] == 8'(y)) begin
        check($sformatf("pin(%0d,%0d)", x, y), k, 32'(orgb[k]), 32'(exp));
        seen = 1;
      end else begin
        tick();
      end
    end
    if (!seen) check("pin_timeout", k, 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int k);
    bit seen = 0;
    for (int c = 0; c < 6000 && !seen; c++) begin
      tick();
      if (odone[k]) seen = 1;
    end
    check("done_seen", k, 32'(seen), 32'd1);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; wready[k] = 1'b1;
      mode[k] = 2'd0; color[k] = 9'h0;
    end
    tick();
    en = 1'b1;
    tick(); tick();
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    tick(); tick();

    // SOLID on 4x2: 8 writes, DONE 9 cycles after START, BUSY drops next.
    begin
      int c;
      mode[0] = 2'd0; color[0] = 9'h1AB;
      pulse_start(0);
      check("first_xy", 0, {16'h0, ox[0], oy[0]}, 32'h0);
      c = 1;
      while (!odone[0] && c < 50) begin
        tick();
        c++;
      end
      check("done_latency", 0, 32'(c), 32'd9);
      check("frame_at_done", 0, 32'(ofr[0]), 32'd1);
      tick();
      check("busy_after", 0, 32'(obusy[0]), 32'd0);
    end

    // GRADIENT on 16x16, frame 0 then frame 1.
    mode[1] = 2'd1; color[1] = 9'h0;
    pulse_start(1);
    pin(1, 9, 5, 9'h06E);
    wait_done(1);
    tick();
    pulse_start(1);
    pin(1, 9, 5, 9'h06F);
    wait_done(1);
    tick();

    // CHECKER, 2-pixel tiles.
    mode[1] = 2'd2; color[1] = 9'h1FF;
    pulse_start(1);
    pin(1, 0, 0, 9'h000);
    pin(1, 2, 0, 9'h1FF);
    pin(1, 3, 1, 9'h1FF);
    pin(1, 2, 2, 9'h000);
    wait_done(1);
    tick();

    // BORDER on 4x4; then START held across FIN and first IDLE cycle.
    mode[2] = 2'd3; color[2] = 9'h007;
    pulse_start(2);
    pin(2, 1, 1, 9'h1F8);
    pin(2, 0, 2, 9'h007);
    pin(2, 2, 2, 9'h1F8);
    pin(2, 3, 3, 9'h007);
    wait_done(2);
    start[2] = 1'b1;
    tick();
    tick();
    start[2] = 1'b0;
    check("restart_after_fin", 2, 32'(owv[2]), 32'd1);
    wait_done(2);
    check("frame_count", 2, 32'(ofr[2]), 32'd2);
    tick();

    // Random WREADY ~30% with START spam while busy.
    begin
      int hs;
      bit seen;
      hs = 0; seen = 0;
      mode[1] = 2'd1;
      pulse_start(1);
      for (int c = 0; c < 6000 && !seen; c++) begin
        wready[1] = ($urandom_range(0, 9) < 3);
        start[1]  = (c % 97 == 50);
        if (owv[1] && wready[1]) hs++;
        tick();
        if (odone[1]) seen = 1;
      end
      wready[1] = 1'b1;
      start[1]  = 1'b0;
      check("rand_done", 1, 32'(seen), 32'd1);
      check("handshakes", 1, 32'(hs), 32'd256);
      check("rand_frame", 1, 32'(ofr[1]), 32'd4);
      tick(); tick(); tick();
      check("no_extra_frame", 1, 32'(obusy[1]), 32'd0);
    end

    // Reset mid-frame at pixel (2,1).
    begin
      bit seen;
      seen = 0;
      mode[1] = 2'd0; color[1] = 9'h155;
      pulse_start(1);
      for (int c = 0; c < 100 && !seen; c++) begin
        if (owv[1] && ox[1] == 8'd2 && oy[1] == 8'd1) seen = 1;
        else tick();
      end
      check("reach_2_1", 1, 32'(seen), 32'd1);
      rst[1] = 1'b1;
      tick();
      check("rst_wvalid", 1, 32'(owv[1]), 32'd0);
      check("rst_busy",   1, 32'(obusy[1]), 32'd0);
      check("rst_frame",  1, 32'(ofr[1]), 32'd0);
      check("rst_done",   1, 32'(odone[1]), 32'd0);
      rst[1] = 1'b0;
      tick();
      pulse_start(1);
      pin(1, 0, 0, 9'h155);
      wait_done(1);
      check("frame_after_rst", 1, 32'(ofr[1]), 32'd1);
      tick(); tick();
    end

    en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
